audio_i2s: RTL and testbench

AUDIO_I2S -- requirements
Module: audio_i2s

---
 rtl/audio_pkg.sv | 16 +
 rtl/audio_dsm.sv | 34 +++
 rtl/audio_i2s.sv | 116 +++++++++++
 tb/tb_audio_i2s.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared widths, frame geometry and sample conversion for the audio I2S block.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package audio_pkg;

  localparam int SAMPLE_W       = 15;  // unsigned mix sample width
  localparam int I2S_W          = 16;  // signed word width on the wire
  localparam int FRAME_SLOTS    = 32;  // BCLK periods per stereo frame
  localparam int LEFT_LAST_SLOT = 15;  // last slot with word select low

  // Unsigned offset-binary (0x4000 = silence) to signed 16-bit, LSB padded with zero.
  function automatic logic [I2S_W-1:0] to_i2s(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/audio_dsm.sv
// First-order sigma-delta DAC channel, only built when AUDIO_SIGMADELTA_EN is defined.
// Latency: output is the registered accumulator carry, one clock behind the input.
// Backpressure: none; samples the live input every clock.
`ifdef AUDIO_SIGMADELTA_EN
module audio_dsm
  import audio_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] din,
  output logic                dout
);

  logic [SAMPLE_W:0] acc_q;
  logic [SAMPLE_W:0] acc_d;

  // Drop the previous carry and add the new sample; the new carry is the pulse output.
  always_comb begin
    acc_d = {1'b0, acc_q[SAMPLE_W-1:0]} + {1'b0, din};
  end

  // Accumulator register.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign dout = acc_q[SAMPLE_W];

endmodule
`endif

// File: rtl/audio_i2s.sv
// Stereo Philips-I2S serializer (optional sigma-delta outputs under AUDIO_SIGMADELTA_EN).
// Latency: samples captured at frame wrap appear on i2s_data from slot 1 of the next frame.
// Backpressure: none; strobe marks the single cycle on which left/right are taken.
module audio_i2s
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  output logic                strobe,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_data
`ifdef AUDIO_SIGMADELTA_EN
  ,
  output logic                dsm_l,
  output logic                dsm_r
`endif
);

  localparam logic [7:0] DIV_TC    = 8'(BCLK_DIV - 1);
  localparam logic [4:0] LAST_SLOT = 5'(FRAME_SLOTS - 1);
  localparam logic [4:0] LEFT_LAST = 5'(LEFT_LAST_SLOT);

  logic [7:0]         div_q, div_d;
  logic               bclk_q, bclk_d;
  logic [4:0]         slot_q, slot_d;
  logic               lrck_q, lrck_d;
  logic               data_q, data_d;
  logic [2*I2S_W-1:0] word_q, word_d;
  logic [4:0]         bit_idx;
  logic               div_tc;
  logic               bclk_fall;
  logic               frame_wrap;

  // Next-state: BCLK divider, slot counter, word select and serial bit all move on BCLK fall.
  always_comb begin
    div_d      = div_q;
    bclk_d     = bclk_q;
    slot_d     = slot_q;
    lrck_d     = lrck_q;
    data_d     = data_q;
    word_d     = word_q;
    bit_idx    = '0;
    div_tc     = (div_q == DIV_TC);
    bclk_fall  = div_tc && bclk_q;
    frame_wrap = bclk_fall && (slot_q == LAST_SLOT);

    if (div_tc) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d = div_q + 8'd1;
    end

    if (bclk_fall) begin
      slot_d = slot_q + 5'd1;
      lrck_d = (slot_d > LEFT_LAST);
      // Slot s carries word bit (32 - s) mod 32, so slot 0 picks bit 0 of the word
      // still held in word_q: the previous frame's right LSB (the one-BCLK I2S delay).
      bit_idx = 5'd0 - slot_d;
      data_d  = word_q[bit_idx];
    end

    // The whole frame is latched at once so it can never be torn by input changes.
    if (frame_wrap) begin
      word_d = {to_i2s(left), to_i2s(right)};
    end
  end

  // State registers; reset aborts any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      slot_q <= '0;
      lrck_q <= 1'b0;
      data_q <= 1'b0;
      word_q <= '0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
      slot_q <= slot_d;
      lrck_q <= lrck_d;
      data_q <= data_d;
      word_q <= word_d;
    end
  end

  assign strobe   = frame_wrap && !reset;
  assign i2s_bclk = bclk_q;
  assign i2s_lrck = lrck_q;
  assign i2s_data = data_q;

`ifdef AUDIO_SIGMADELTA_EN
  audio_dsm u_dsm_l (
    .clock (clock),
    .reset (reset),
    .din   (left),
    .dout  (dsm_l)
  );

  audio_dsm u_dsm_r (
    .clock (clock),
    .reset (reset),
    .din   (right),
    .dout  (dsm_r)
  );
`else
  // Sigma-delta outputs not built.
`endif

endmodule

// File: tb/tb_audio_i2s.sv
// Directed bench for audio_i2s with BCLK_DIV = 4 and a BCLK-rising-edge frame decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_i2s;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] left;
  logic [14:0] right;
  logic        strobe;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_data;
`ifdef AUDIO_SIGMADELTA_EN
  logic        dsm_l;
  logic        dsm_r;
`endif

  audio_i2s #(.BCLK_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .left     (left),
    .right    (right),
    .strobe   (strobe),
    .i2s_bclk (i2s_bclk),
    .i2s_lrck (i2s_lrck),
    .i2s_data (i2s_data)
`ifdef AUDIO_SIGMADELTA_EN
    ,
    .dsm_l    (dsm_l),
    .dsm_r    (dsm_r)
`endif
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;

  // Monitor state: cycle index since reset release, event times, decoded words.
  int          cyc;
  int          bclk_rise[$];
  int          lrck_rise[$];
  int          strobe_cyc[$];
  logic [31:0] words[$];
  logic        bits_by_slot[32];
  logic        data_or;
  logic        pbclk;
  logic        plrck;
  logic        lrck_at_rise;
  logic [4:0]  dslot;
  logic [31:0] sr;
  bit          dec_wrap;

  // Sample 1 time unit after each rising clock edge; decode on BCLK rises.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      cyc = 0;
      bclk_rise.delete();
      lrck_rise.delete();
      strobe_cyc.delete();
      words.delete();
      pbclk        = 1'b0;
      plrck        = 1'b0;
      lrck_at_rise = 1'b0;
      dslot        = 5'd31;
      sr           = '0;
      data_or      = 1'b0;
    end else begin
      cyc++;
      if (cyc < 256) data_or = data_or | i2s_data;
      if (strobe) strobe_cyc.push_back(cyc);
      if (i2s_lrck && !plrck) lrck_rise.push_back(cyc);
      if (i2s_bclk && !pbclk) begin
        bclk_rise.push_back(cyc);
        dec_wrap = !i2s_lrck && lrck_at_rise;
        dslot    = dec_wrap ? 5'd0 : dslot + 5'd1;
        sr       = {sr[30:0], i2s_data};
        bits_by_slot[dslot] = i2s_data;
        if (dec_wrap) words.push_back(sr);
        lrck_at_rise = i2s_lrck;
      end
      pbclk = i2s_bclk;
      plrck = i2s_lrck;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Timing after a release 600 clocks ago: BCLK rises at 4,12,..,596; LRCK rises at
  // 128 and 384; strobe (capture cycle) at 255 and 511; words decoded at 260 and 516.
  task automatic timing_checks(input string pfx, input logic [31:0] word1_exp);
    check({pfx, "_bclk_count"},   bclk_rise.size(), 75);
    check({pfx, "_bclk_first"},   bclk_rise[0], 4);
    check({pfx, "_bclk_period"},  bclk_rise[1] - bclk_rise[0], 8);
    check({pfx, "_lrck_first"},   lrck_rise[0], 128);
    check({pfx, "_lrck_period"},  lrck_rise[1] - lrck_rise[0], 256);
    check({pfx, "_strobe_count"}, strobe_cyc.size(), 2);
    check({pfx, "_strobe_first"}, strobe_cyc[0], 255);
    check({pfx, "_strobe_period"}, strobe_cyc[1] - strobe_cyc[0], 256);
    check({pfx, "_frame1_bits"},  data_or, 0);
    check({pfx, "_word_count"},   words.size(), 2);
    check({pfx, "_word0"},        words[0], 32'h0000_0000);
    check({pfx, "_word1"},        words[1], word1_exp);
  endtask

`ifdef AUDIO_SIGMADELTA_EN
  int ones;
`endif

  initial begin
    left  = 15'h4000;
    right = 15'h4000;

    // Reset state.
    repeat (5) @(negedge clock);
    check("rst_bclk",   i2s_bclk, 0);
    check("rst_lrck",   i2s_lrck, 0);
    check("rst_data",   i2s_data, 0);
    check("rst_strobe", strobe,   0);

    // Boot timing and silence.
    reset = 1'b0;
    repeat (600) @(negedge clock);
    timing_checks("boot", 32'h0000_0000);

    // Full-scale left, minimum right: captured at clock 768, decoded as word 3.
    left  = 15'h7FFF;
    right = 15'h0000;
    repeat (500) @(negedge clock);
    check("word2_silence", words[2], 32'h0000_0000);
    check("word3_lr",      words[3], 32'h7FFE_8000);
    check("slot1_l_msb",   bits_by_slot[1],  0);
    check("slot2_l_b14",   bits_by_slot[2],  1);
    check("slot17_r_msb",  bits_by_slot[17], 1);
    check("slot18_r_b14",  bits_by_slot[18], 0);

    // Left 0x1234 captured at 1280; change to 0x5555 mid-frame at 1400, captured at 1536.
    left = 15'h1234;
    repeat (300) @(negedge clock);
    left = 15'h5555;
    repeat (555) @(negedge clock);
    check("word4_lr",    words[4], 32'h7FFE_8000);
    check("word5_1234",  words[5], 32'hA468_8000);
    check("word6_5555",  words[6], 32'h2AAA_8000);

    // Clock 1955 is inside slot 20 (word select high); reset for 3 clocks.
    check("pre_rst_lrck", i2s_lrck, 1);
    reset = 1'b1;
    repeat (1) @(negedge clock);
    check("mid_rst_bclk",   i2s_bclk, 0);
    check("mid_rst_lrck",   i2s_lrck, 0);
    check("mid_rst_data",   i2s_data, 0);
    check("mid_rst_strobe", strobe,   0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (600) @(negedge clock);
    timing_checks("restart", 32'h2AAA_8000);

`ifdef AUDIO_SIGMADELTA_EN
    left = 15'h4000;
    repeat (4) @(negedge clock);
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clock);
      if (dsm_l) ones++;
    end
    check("dsm_half_duty", ones, 2048);
    left = 15'h0000;
    repeat (4) @(negedge clock);
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (dsm_l) ones++;
    end
    check("dsm_zero", ones, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
